// File: rtl/dot_led_scan_ctrl_if.sv
// Bus bundle between the dot-LED scan sequencer, its frame-buffer read port and the panel pins.
// Optional DOT_LED_DIM_EN adds the dim_shift brightness input.
interface dot_led_scan_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 32
);
  localparam int ADDR_W = $clog2(ROWS * COLS);
  localparam int ROW_W  = $clog2(ROWS);

  logic              ctrl_enable;
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [23:0]       fb_rd_data;
  logic              led_r;
  logic              led_g;
  logic              led_b;
  logic              led_sclk;
  logic              led_lat;
  logic              led_oe_n;
  logic [ROW_W-1:0]  led_row;
  logic              busy;
  logic              frame_done;
`ifdef DOT_LED_DIM_EN
  logic [1:0]        dim_shift;
`endif

  // The sequencer drives the frame-buffer read port and the panel.
  modport master (
    input  ctrl_enable,
    input  fb_rd_data,
`ifdef DOT_LED_DIM_EN
    input  dim_shift,
`endif
    output fb_rd_en,
    output fb_rd_addr,
    output led_r,
    output led_g,
    output led_b,
    output led_sclk,
    output led_lat,
    output led_oe_n,
    output led_row,
    output busy,
    output frame_done
  );

  modport slave (
    output ctrl_enable,
    output fb_rd_data,
`ifdef DOT_LED_DIM_EN
    output dim_shift,
`endif
    input  fb_rd_en,
    input  fb_rd_addr,
    input  led_r,
    input  led_g,
    input  led_b,
    input  led_sclk,
    input  led_lat,
    input  led_oe_n,
    input  led_row,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/dot_led_scan_ctrl.sv
// Row-scanning bit-plane sequencer for an RGB dot-LED matrix with binary-coded OE modulation.
// Define DOT_LED_DIM_EN to shorten the lit part of each DISPLAY period by dim_shift.
module dot_led_scan_ctrl #(
  parameter int ROWS       = 8,
  parameter int COLS       = 32,
  parameter int COLOR_BITS = 8,
  parameter int BASE_TICKS = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  dot_led_scan_ctrl_if.master   bus
);
  localparam int ADDR_W   = $clog2(ROWS * COLS);
  localparam int ROW_W    = $clog2(ROWS);
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PL_W     = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int DIV_W    = $clog2(CLK_DIV) + 1;
  localparam int DISP_MAX = BASE_TICKS << (COLOR_BITS - 1);
  localparam int DISP_W   = $clog2(DISP_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_DISPLAY, S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PL_W-1:0]   plane_q, plane_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [2:0]        rgb_q, rgb_d;
  logic [1:0]        dim_q, dim_d;

  logic [2:0]        bit_idx;
  logic [7:0]        r_ch, g_ch, b_ch;
  logic [DISP_W-1:0] disp_len, on_len;
  logic              last_div;

  // Plane 0 is the least significant of the COLOR_BITS planes kept from each 8-bit channel.
  assign bit_idx  = 3'(8 - COLOR_BITS) + 3'(plane_q);
  assign r_ch     = bus.fb_rd_data[23:16];
  assign g_ch     = bus.fb_rd_data[15:8];
  assign b_ch     = bus.fb_rd_data[7:0];
  assign disp_len = DISP_W'(BASE_TICKS) << plane_q;
  assign on_len   = disp_len >> dim_q;
  assign last_div = (div_q == DIV_W'(CLK_DIV - 1));

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    plane_d = plane_q;
    div_d   = div_q;
    disp_d  = disp_q;
    rgb_d   = rgb_q;
    dim_d   = dim_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ctrl_enable) begin
          row_d   = '0;
          col_d   = '0;
          plane_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        rgb_d   = {r_ch[bit_idx], g_ch[bit_idx], b_ch[bit_idx]};
        div_d   = '0;
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (last_div) begin
          div_d   = '0;
          state_d = S_SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_SHIFT_HI: begin
        if (last_div) begin
          div_d = '0;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d   = '0;
            state_d = S_LATCH;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        disp_d  = '0;
`ifdef DOT_LED_DIM_EN
        dim_d   = bus.dim_shift;
`else
        dim_d   = 2'd0;
`endif
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (disp_q == disp_len - DISP_W'(1)) begin
          disp_d = '0;
          if (plane_q == PL_W'(COLOR_BITS - 1)) begin
            state_d = S_NEXT;
          end else begin
            plane_d = plane_q + PL_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          disp_d = disp_q + DISP_W'(1);
        end
      end
      S_NEXT: begin
        row_d   = row_q + ROW_W'(1);
        plane_d = '0;
        // Enable is only re-sampled at the frame wrap so a frame is never cut short.
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = bus.ctrl_enable ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      plane_q <= '0;
      div_q   <= '0;
      disp_q  <= '0;
      rgb_q   <= '0;
      dim_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      plane_q <= plane_d;
      div_q   <= div_d;
      disp_q  <= disp_d;
      rgb_q   <= rgb_d;
      dim_q   <= dim_d;
    end
  end

  // Panel strobes decode straight from the state register, so reset clears them immediately.
  assign bus.fb_rd_en   = (state_q == S_FETCH);
  assign bus.fb_rd_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign bus.led_r      = rgb_q[2];
  assign bus.led_g      = rgb_q[1];
  assign bus.led_b      = rgb_q[0];
  assign bus.led_sclk   = (state_q == S_SHIFT_HI);
  assign bus.led_lat    = (state_q == S_LATCH);
  assign bus.led_oe_n   = !((state_q == S_DISPLAY) && (disp_q < on_len));
  assign bus.led_row    = row_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_NEXT) && (row_q == ROW_W'(ROWS - 1));
endmodule

// File: tb/tb_dot_led_scan_ctrl.sv
// Directed bench for dot_led_scan_ctrl: small 2x4 panel, 2 planes, 1-cycle frame-buffer model.
module tb_dot_led_scan_ctrl;
  localparam int ROWS = 2, COLS = 4, COLOR_BITS = 2, BASE_TICKS = 4, CLK_DIV = 1;
  localparam int FRAME_CYC = 94;

  logic ACLK = 1'b0;
  logic ARESET = 1'b0;
  always #5 ACLK = ~ACLK;

  dot_led_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  dot_led_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .COLOR_BITS(COLOR_BITS),
    .BASE_TICKS(BASE_TICKS), .CLK_DIV(CLK_DIV)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(bus)
  );

  logic [23:0] fb_mem [0:ROWS*COLS-1];
  always @(posedge ACLK) if (bus.fb_rd_en) bus.fb_rd_data <= fb_mem[bus.fb_rd_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Panel monitor, sampled on the falling edge.
  logic       mon_en = 1'b0;
  logic       sclk_prev = 1'b0;
  logic       oe_prev = 1'b1;
  logic [2:0] rise_q[$];
  int         lat_sclk_q[$];
  int         oe_run_q[$];
  int         oe_row_q[$];
  int         sclk_since_lat, oe_run, fd_cnt, fd_bad, busy_cnt;

  always @(negedge ACLK) begin
    if (mon_en) begin
      if (bus.led_sclk && !sclk_prev) begin
        rise_q.push_back({bus.led_r, bus.led_g, bus.led_b});
        sclk_since_lat++;
      end
      if (bus.led_lat) begin
        lat_sclk_q.push_back(sclk_since_lat);
        sclk_since_lat = 0;
      end
      if (!bus.led_oe_n) begin
        if (oe_prev) oe_row_q.push_back(int'(bus.led_row));
        oe_run++;
      end else if (!oe_prev) begin
        oe_run_q.push_back(oe_run);
        oe_run = 0;
      end
      if (bus.frame_done) begin
        fd_cnt++;
        if (!bus.led_oe_n || bus.led_sclk || bus.led_lat || !bus.busy || bus.led_row != 1'b1)
          fd_bad++;
      end
      if (bus.busy) busy_cnt++;
    end
    sclk_prev = bus.led_sclk;
    oe_prev   = bus.led_oe_n;
  end

  task automatic clear_mon();
    rise_q.delete();
    lat_sclk_q.delete();
    oe_run_q.delete();
    oe_row_q.delete();
    sclk_since_lat = 0;
    oe_run = 0;
    fd_cnt = 0;
    fd_bad = 0;
    busy_cnt = 0;
  endtask

  task automatic fill_fb(input logic [23:0] val);
    for (int i = 0; i < ROWS * COLS; i++) fb_mem[i] = val;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (bus.busy && n < 400);
    check({tag, "_idle_timeout"}, bus.busy, 1'b0);
  endtask

  // One frame: raise enable for a single cycle so the sequencer stops after the wrap.
  task automatic run_one_frame(input string tag);
    clear_mon();
    mon_en = 1'b1;
    @(negedge ACLK);
    bus.ctrl_enable = 1'b1;
    @(negedge ACLK);
    bus.ctrl_enable = 1'b0;
    wait_idle(tag);
    @(negedge ACLK);
    mon_en = 1'b0;
  endtask

  initial begin
    int n, frames, seen;
    int exp_run [8]  = '{4, 8, 4, 8, 4, 8, 4, 8};
    int exp_row [8]  = '{0, 0, 1, 1, 0, 0, 1, 1};

    bus.ctrl_enable = 1'b1;
`ifdef DOT_LED_DIM_EN
    bus.dim_shift = 2'd0;
`endif
    fill_fb(24'h0);

    // Reset dominates an asserted enable.
    #1 ARESET = 1'b1;
    #1;
    check("rst_fb_rd_en", bus.fb_rd_en, 1'b0);
    check("rst_fb_rd_addr", bus.fb_rd_addr, 0);
    check("rst_rgb", {bus.led_r, bus.led_g, bus.led_b}, 3'b000);
    check("rst_sclk", bus.led_sclk, 1'b0);
    check("rst_lat", bus.led_lat, 1'b0);
    check("rst_oe_n", bus.led_oe_n, 1'b1);
    check("rst_row", bus.led_row, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_frame_done", bus.frame_done, 1'b0);
    repeat (3) @(negedge ACLK);
    check("rst_hold_busy", bus.busy, 1'b0);
    bus.ctrl_enable = 1'b0;
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    // Two back-to-back frames of pure red.
    fill_fb(24'hFF0000);
    clear_mon();
    mon_en = 1'b1;
    @(negedge ACLK);
    bus.ctrl_enable = 1'b1;
    frames = 0;
    n = 0;
    while (frames < 2 && n < 400) begin
      @(negedge ACLK);
      n++;
      if (bus.frame_done) frames++;
    end
    bus.ctrl_enable = 1'b0;
    check("red_frames_timeout", frames, 2);
    repeat (2) @(negedge ACLK);
    mon_en = 1'b0;
    check("red_busy_after", bus.busy, 1'b0);
    check("red_oe_n_after", bus.led_oe_n, 1'b1);
    check("red_fd_cnt", fd_cnt, 2);
    check("red_fd_bad", fd_bad, 0);
    check("red_busy_cycles", busy_cnt, 2 * FRAME_CYC);
    check("red_rise_count", rise_q.size(), 32);
    foreach (rise_q[i]) check($sformatf("red_rgb_%0d", i), rise_q[i], 3'b100);
    check("red_lat_count", lat_sclk_q.size(), 8);
    foreach (lat_sclk_q[i]) check($sformatf("red_sclk_per_lat_%0d", i), lat_sclk_q[i], 4);
    check("red_oe_runs", oe_run_q.size(), 8);
    for (int i = 0; i < 8 && i < oe_run_q.size(); i++)
      check($sformatf("red_oe_len_%0d", i), oe_run_q[i], exp_run[i]);
    check("red_oe_rows", oe_row_q.size(), 8);
    for (int i = 0; i < 8 && i < oe_row_q.size(); i++)
      check($sformatf("red_oe_row_%0d", i), oe_row_q[i], exp_row[i]);

    // Single blue MSB pixel at address 5: row 1, column 1, visible only in plane 1.
    fill_fb(24'h0);
    fb_mem[5] = 24'h000080;
    run_one_frame("blue");
    check("blue_rise_count", rise_q.size(), 16);
    foreach (rise_q[i])
      check($sformatf("blue_rgb_%0d", i), rise_q[i], (i == 13) ? 3'b001 : 3'b000);
    check("blue_fd_cnt", fd_cnt, 1);
    check("blue_busy_cycles", busy_cnt, FRAME_CYC);

    // Drop enable during row 0 plane 1: the frame still completes.
    fill_fb(24'h0);
    clear_mon();
    mon_en = 1'b1;
    @(negedge ACLK);
    bus.ctrl_enable = 1'b1;
    n = 0;
    while (!bus.led_lat && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check("drop_first_lat_timeout", bus.led_lat, 1'b1);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 200) begin
      @(negedge ACLK);
      n++;
      if (bus.led_sclk) seen++;
    end
    check("drop_plane1_sclk_timeout", seen, 2);
    bus.ctrl_enable = 1'b0;
    wait_idle("drop");
    @(negedge ACLK);
    mon_en = 1'b0;
    check("drop_fd_cnt", fd_cnt, 1);
    check("drop_oe_runs", oe_run_q.size(), 4);
    check("drop_busy_cycles", busy_cnt, FRAME_CYC);
    check("drop_oe_n_idle", bus.led_oe_n, 1'b1);
    repeat (20) @(negedge ACLK);
    check("drop_stays_idle", bus.busy, 1'b0);

`ifdef DOT_LED_DIM_EN
    // Half brightness: lit time halves, frame length does not.
    bus.dim_shift = 2'd1;
    run_one_frame("dim");
    bus.dim_shift = 2'd0;
    check("dim_oe_runs", oe_run_q.size(), 4);
    for (int i = 0; i < 4 && i < oe_run_q.size(); i++)
      check($sformatf("dim_oe_len_%0d", i), oe_run_q[i], exp_run[i] / 2);
    check("dim_busy_cycles", busy_cnt, FRAME_CYC);
`endif

    // Asynchronous reset in SHIFT_HI of row 1 clears the panel pins without a clock edge.
    fill_fb(24'hFF0000);
    @(negedge ACLK);
    bus.ctrl_enable = 1'b1;
    n = 0;
    while (!(bus.led_sclk && bus.led_row == 1'b1) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check("arst_pre_sclk", bus.led_sclk, 1'b1);
    check("arst_pre_r", bus.led_r, 1'b1);
    #1 ARESET = 1'b1;
    #1;
    check("arst_sclk", bus.led_sclk, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_row", bus.led_row, 1'b0);
    check("arst_r", bus.led_r, 1'b0);
    check("arst_oe_n", bus.led_oe_n, 1'b1);
    check("arst_fb_rd_addr", bus.fb_rd_addr, 0);
    @(negedge ACLK);
    bus.ctrl_enable = 1'b0;
    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    check("arst_idle_after", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
